// File: rtl/regfile_mp.sv
// Multi-port integer register file: NREAD registered read ports, ALU/LSU write ports, pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NREAD*AW-1:0]    i_raddr,
    output logic [NREAD*XLEN-1:0]  o_rdata,
    output logic [NREAD-1:0]       o_rbusy,
    input  logic                   i_we0,
    input  logic [AW-1:0]          i_waddr0,
    input  logic [XLEN-1:0]        i_wdata0,
    input  logic                   i_we1,
    input  logic [AW-1:0]          i_waddr1,
    input  logic [XLEN-1:0]        i_wdata1,
    input  logic                   i_rsv_en,
    input  logic [AW-1:0]          i_rsv_addr,
    output logic [AW:0]            o_pending_cnt
);

    logic [XLEN-1:0]       r_mem [NREGS];
    logic [NREGS-1:0]      r_pend;
    logic [NREAD*XLEN-1:0] r_rdata;
    logic [NREAD-1:0]      r_rbusy;
    logic [AW:0]           r_cnt;

    logic [NREGS-1:0]      w_set;
    logic [NREGS-1:0]      w_clr;
    logic [NREGS-1:0]      w_pend_nxt;
    logic [AW:0]           w_inc;
    logic [AW:0]           w_dec;
    logic [AW-1:0]         w_raddr [NREAD];
    logic [NREAD*XLEN-1:0] w_rdata;
    logic [NREAD-1:0]      w_rbusy;

    // Reserve wins over a same-cycle clear so a new producer stays tracked.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_rsv_en) w_set[i_rsv_addr] = 1'b1;
        if (i_we0)    w_clr[i_waddr0]   = 1'b1;
        if (i_we1)    w_clr[i_waddr1]   = 1'b1;
        w_pend_nxt    = (r_pend & ~w_clr) | w_set;
        w_pend_nxt[0] = 1'b0;
        w_inc = '0;
        w_dec = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_inc = w_inc + {{AW{1'b0}}, w_pend_nxt[i] & ~r_pend[i]};
            w_dec = w_dec + {{AW{1'b0}}, r_pend[i] & ~w_pend_nxt[i]};
        end
    end

    always_comb begin
        w_rdata = '0;
        w_rbusy = '0;
        for (int k = 0; k < NREAD; k++) begin
            w_raddr[k] = i_raddr[k*AW +: AW];
            if (w_raddr[k] == '0) begin
                w_rdata[k*XLEN +: XLEN] = '0;
                w_rbusy[k]              = 1'b0;
            end else begin
`ifdef REGFILE_BYPASS_EN
                if (i_we1 && i_waddr1 == w_raddr[k])
                    w_rdata[k*XLEN +: XLEN] = i_wdata1;
                else if (i_we0 && i_waddr0 == w_raddr[k])
                    w_rdata[k*XLEN +: XLEN] = i_wdata0;
                else
                    w_rdata[k*XLEN +: XLEN] = r_mem[w_raddr[k]];
                w_rbusy[k] = w_pend_nxt[w_raddr[k]];
`else
                w_rdata[k*XLEN +: XLEN] = r_mem[w_raddr[k]];
                w_rbusy[k]              = r_pend[w_raddr[k]];
`endif
            end
        end
    end

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
            r_pend  <= '0;
            r_rdata <= '0;
            r_rbusy <= '0;
            r_cnt   <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (i_we1 && i_waddr1 == AW'(i))
                    r_mem[i] <= i_wdata1;
                else if (i_we0 && i_waddr0 == AW'(i))
                    r_mem[i] <= i_wdata0;
            end
            r_pend  <= w_pend_nxt;
            r_rdata <= w_rdata;
            r_rbusy <= w_rbusy;
            r_cnt   <= r_cnt + w_inc - w_dec;
        end
    end

    assign o_rdata       = r_rdata;
    assign o_rbusy       = r_rbusy;
    assign o_pending_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic against an array-based model.
module tb_regfile_mp;

    localparam int XLEN = 32, NREGS = 32, NREAD = 2, AW = 5;

    logic                  i_clk = 1'b0;
    logic                  i_reset = 1'b1;
    logic [NREAD*AW-1:0]   i_raddr = '0;
    logic [NREAD*XLEN-1:0] o_rdata;
    logic [NREAD-1:0]      o_rbusy;
    logic                  i_we0 = 1'b0, i_we1 = 1'b0, i_rsv_en = 1'b0;
    logic [AW-1:0]         i_waddr0 = '0, i_waddr1 = '0, i_rsv_addr = '0;
    logic [XLEN-1:0]       i_wdata0 = '0, i_wdata1 = '0;
    logic [AW:0]           o_pending_cnt;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_raddr(i_raddr), .o_rdata(o_rdata),
        .o_rbusy(o_rbusy), .i_we0(i_we0), .i_waddr0(i_waddr0), .i_wdata0(i_wdata0),
        .i_we1(i_we1), .i_waddr1(i_waddr1), .i_wdata1(i_wdata1), .i_rsv_en(i_rsv_en),
        .i_rsv_addr(i_rsv_addr), .o_pending_cnt(o_pending_cnt)
    );

    always #5 i_clk = ~i_clk;

    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_pend [NREGS];
    int              nvec = 0;
    int              nerr = 0;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < NREGS; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic set_rd(input int a0, input int a1);
        i_raddr = {AW'(a1), AW'(a0)};
    endtask

    task automatic idle();
        i_we0 = 0; i_we1 = 0; i_rsv_en = 0;
    endtask

    // Reads see the register file before this edge's updates, or after them when forwarding is built in.
    task automatic cycle();
        logic [XLEN-1:0] ed [NREAD];
        logic            eb [NREAD];
        int              a;
`ifndef REGFILE_BYPASS_EN
        for (int k = 0; k < NREAD; k++) begin
            a = int'(i_raddr[k*AW +: AW]);
            ed[k] = m_mem[a];
            eb[k] = m_pend[a];
        end
`endif
        if (i_we0 && i_waddr0 != 0) begin m_mem[i_waddr0] = i_wdata0; m_pend[i_waddr0] = 0; end
        if (i_we1 && i_waddr1 != 0) begin m_mem[i_waddr1] = i_wdata1; m_pend[i_waddr1] = 0; end
        if (i_rsv_en && i_rsv_addr != 0) m_pend[i_rsv_addr] = 1;
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NREAD; k++) begin
            a = int'(i_raddr[k*AW +: AW]);
            ed[k] = m_mem[a];
            eb[k] = m_pend[a];
        end
`endif
        @(posedge i_clk);
        #1;
        chk("rdata0", o_rdata[0 +: XLEN], ed[0]);
        chk("rdata1", o_rdata[XLEN +: XLEN], ed[1]);
        chk("rbusy", {30'd0, o_rbusy}, {30'd0, eb[1], eb[0]});
        chk("pending_cnt", {26'd0, o_pending_cnt}, XLEN'(model_cnt()));
    endtask

    initial begin
        model_reset();
        #2;
        chk("reset_rdata", o_rdata[31:0] | o_rdata[63:32], 32'h0);
        chk("reset_cnt", {26'd0, o_pending_cnt}, 32'h0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;

        // Every register reads zero on both ports after reset.
        for (int i = 0; i < NREGS; i++) begin
            set_rd(i, NREGS - 1 - i);
            cycle();
        end

        // Register 0 ignores writes and reservations.
        i_we0 = 1; i_waddr0 = 0; i_wdata0 = 32'hDEADBEEF; set_rd(0, 0);
        cycle(); idle();
        i_rsv_en = 1; i_rsv_addr = 0;
        cycle(); idle();
        chk("r0_read", o_rdata[31:0], 32'h0);
        chk("r0_rsv_cnt", {26'd0, o_pending_cnt}, 32'h0);

        // Same-address dual write: LSU wins; distinct addresses both land.
        i_we0 = 1; i_waddr0 = 5; i_wdata0 = 32'h11111111;
        i_we1 = 1; i_waddr1 = 5; i_wdata1 = 32'h22222222;
        cycle();
        i_waddr0 = 6; i_wdata0 = 32'hA; i_waddr1 = 7; i_wdata1 = 32'hB;
        cycle(); idle();
        set_rd(5, 6); cycle();
        chk("r5_lsu_wins", o_rdata[31:0], 32'h22222222);
        chk("r6_dual", o_rdata[63:32], 32'hA);
        set_rd(7, 7); cycle();
        chk("r7_dual", o_rdata[63:32], 32'hB);

        // Same-cycle write/read hazard.
        i_we0 = 1; i_waddr0 = 9; i_wdata0 = 32'h1234; set_rd(9, 9);
        cycle(); idle();
`ifdef REGFILE_BYPASS_EN
        chk("r9_fwd", o_rdata[31:0], 32'h1234);
`else
        chk("r9_old", o_rdata[31:0], 32'h0);
`endif
        cycle();
        chk("r9_new", o_rdata[31:0], 32'h1234);

        // Scoreboard sequence.
        i_rsv_en = 1; i_rsv_addr = 3; set_rd(3, 4); cycle();
        i_rsv_addr = 4; cycle();
        i_rsv_addr = 3; cycle(); idle();
        cycle();
        chk("sb_cnt2", {26'd0, o_pending_cnt}, 32'd2);
        chk("sb_r3_busy", {31'd0, o_rbusy[0]}, 32'd1);
        i_we0 = 1; i_waddr0 = 3; i_wdata0 = 32'h33; cycle(); idle();
        chk("sb_cnt1", {26'd0, o_pending_cnt}, 32'd1);
        i_we1 = 1; i_waddr1 = 4; i_wdata1 = 32'h44; i_rsv_en = 1; i_rsv_addr = 4;
        cycle(); idle();
        cycle();
        chk("sb_cnt_hold", {26'd0, o_pending_cnt}, 32'd1);
        chk("sb_r4_busy", {31'd0, o_rbusy[1]}, 32'd1);

        // Random traffic, addresses biased toward a small window to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            i_we0 = 1'($urandom); i_we1 = 1'($urandom); i_rsv_en = 1'($urandom);
            i_waddr0 = AW'($urandom_range(0, 7)); i_waddr1 = AW'($urandom_range(0, 7));
            i_rsv_addr = AW'($urandom_range(0, 9));
            i_wdata0 = $urandom; i_wdata1 = $urandom;
            set_rd($urandom_range(0, 9), $urandom_range(0, 31));
            cycle();
        end
        idle();

        // Load everything, reserve r1..r10, then reset asynchronously mid-sequence.
        for (int i = 1; i < NREGS; i++) begin
            i_we0 = 1; i_waddr0 = AW'(i); i_wdata0 = 32'hC000_0000 + i;
            set_rd(i - 1, i);
            cycle();
        end
        idle();
        for (int i = 1; i <= 10; i++) begin
            i_rsv_en = 1; i_rsv_addr = AW'(i); set_rd(i, 12);
            cycle();
        end
        i_rsv_en = 1; i_rsv_addr = 11; i_we1 = 1; i_waddr1 = 12; i_wdata1 = 32'hFFFF;
        #2;
        i_reset = 1'b1;
        #1;
        model_reset();
        chk("async_rdata0", o_rdata[31:0], 32'h0);
        chk("async_rdata1", o_rdata[63:32], 32'h0);
        chk("async_rbusy", {30'd0, o_rbusy}, 32'h0);
        chk("async_cnt", {26'd0, o_pending_cnt}, 32'h0);
        idle();
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        set_rd(12, 1);
        cycle();
        chk("post_reset_r12", o_rdata[31:0], 32'h0);
        chk("post_reset_cnt", {26'd0, o_pending_cnt}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the Argon core, replacing the fixed 2R1W file. It provides NREAD registered read ports and two write ports, one for ALU writeback and one for LSU writeback. An integrated scoreboard tracks registers with an outstanding write, so issue logic can stall on hazards. Register 0 is hardwired to zero.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, at least 4); index 0 is constant zero
NREAD, 2, number of read ports (1..4)
AW, $clog2(NREGS), address width (derived; not to be overridden)

Ports:
i_clk  input  1  clock
i_reset  input  1  asynchronous, active-high reset
i_raddr  input  NREAD*AW  read addresses; port k occupies bits [k*AW +: AW]
o_rdata  output  NREAD*XLEN  registered read data; port k occupies [k*XLEN +: XLEN]
o_rbusy  output  NREAD  registered scoreboard-pending flag per read port
i_we0  input  1  write enable, port 0 (ALU)
i_waddr0  input  AW  write address, port 0
i_wdata0  input  XLEN  write data, port 0
i_we1  input  1  write enable, port 1 (LSU)
i_waddr1  input  AW  write address, port 1
i_wdata1  input  XLEN  write data, port 1
i_rsv_en  input  1  reserve (mark pending) strobe
i_rsv_addr  input  AW  register to mark pending
o_pending_cnt  output  AW+1  number of registers currently pending

Behaviour:
- Reset is asynchronous. While i_reset is high, all registers 1..NREGS-1 = 0, all pending bits = 0, o_rdata = 0, o_rbusy = 0, o_pending_cnt = 0. Reset asserted mid-operation discards in-flight writes and reservations.
- Register 0 is a constant, not storage:
  - writes to address 0 are ignored;
  - reserve of address 0 is ignored;
  - reads of address 0 return 0 with busy = 0.
- Writes:
  - Take effect at the posedge when the enable is high.
  - If both ports write the same non-zero address in one cycle, port 1 (LSU) wins.
  - Writes to different addresses in one cycle both commit.
- Reads:
  - 1-cycle latency. i_raddr is sampled at posedge N; o_rdata/o_rbusy are valid after posedge N and held until the next edge.
  - Read ports are independent; any number of ports may read the same address.
- Scoreboard:
  - One pending bit per register.
  - i_rsv_en sets pending[i_rsv_addr].
  - Any committed write clears the pending bit of its address.
  - Reserve and write to the same address in one cycle: pending ends set. A new producer is issuing while the old one retires.
  - Reserve of an already-pending register leaves it set; o_pending_cnt does not change.
- o_pending_cnt:
  - Registered population count of the pending bits.
  - Updated each cycle by +1 per newly-set bit and -1 per cleared bit.
  - Range 0..NREGS-1; it cannot overflow because register 0 is never pending.
- Same-cycle read/write hazard: governed by REGFILE_BYPASS_EN (see Optional Feature).
- o_rbusy[k]: pending bit of the read address, using the same old/new view as o_rdata[k].

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If a read address matches a same-cycle committed write, o_rdata returns the new data, with port-1 priority.
  - o_rbusy reflects the post-update pending state, e.g. a write that clears pending reads busy = 0.
- Undefined: no forwarding.
  - o_rdata returns the array contents before this edge's writes.
  - o_rbusy reflects the pre-update pending state.
  - Issue logic must stall one extra cycle on a write-to-read hazard.

Test Plan:
- Reset then read r0..r31 on all ports -> all o_rdata = 0, o_rbusy = 0, o_pending_cnt = 0.
- Write r0 = 0xDEADBEEF, then read r0 -> o_rdata = 0. Reserve r0 -> o_pending_cnt stays 0.
- Same cycle: we0 r5 = 0x11111111 and we1 r5 = 0x22222222; next cycle read r5 -> 0x22222222. Dual writes r6 = 0xA, r7 = 0xB in one cycle -> both read back correctly.
- Write r9 = 0x1234 and read r9 in the same cycle:
  - with REGFILE_BYPASS_EN -> o_rdata = 0x1234;
  - without it -> previous value (0), with 0x1234 on the following read.
- Reserve r3, r4, r3 over three cycles -> o_pending_cnt = 2, o_rbusy = 1 for r3. Then:
  - write r3 -> cnt = 1;
  - same-cycle write r4 plus reserve r4 -> cnt stays 1, r4 busy.
- Load r1..r31, reserve r1..r10, assert i_reset mid-sequence -> outputs 0 immediately (asynchronous). After deassert, read r12 -> 0 and o_pending_cnt = 0.
